// File: rtl/serial_link_obi_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_obi_guard_pkg
// Purpose  : Shared types and constants for the serial-link OBI guard.
//            - state_e            : guard state (RUN / FLUSH)
//            - c_err_data_default : rdata returned on a synthesized error
//            - c_stats_width      : width of the timeout statistics counter
// Revision : 1.0 - initial release
// ============================================================================
package serial_link_obi_guard_pkg;

  // RUN: traffic forwarded to the link. FLUSH: issuing error responses.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [31:0] c_err_data_default = 32'hBADC_AB1E;
  localparam int unsigned c_stats_width      = 16;

endpackage : serial_link_obi_guard_pkg
`default_nettype wire

// File: rtl/serial_link_obi_guard_timer.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_obi_guard_timer
// Purpose  : Clearable up-counter with compare against a programmable limit.
//            expire_o is a single-cycle pulse on the cycle the counter sits at
//            limit_i-1 while not being cleared; the counter restarts from 0
//            after an expiry. A limit of 0 disables the timer.
// Ports    : clk_i, rst_ni  - clock, asynchronous active-low reset
//            clr_i          - hold the counter at zero / suppress expiry
//            limit_i        - timeout in cycles (0 = disabled)
//            expire_o       - expiry pulse
// Revision : 1.0 - initial release
// ============================================================================
module serial_link_obi_guard_timer
  import serial_link_obi_guard_pkg::*;
#(
  parameter int unsigned TimeoutWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic [TimeoutWidth-1:0] limit_i,
  output logic                    expire_o
);

  logic [TimeoutWidth-1:0] count_q, count_d;
  logic                    disabled;

  assign disabled = (limit_i == '0);

  // limit_i is compared live so a new value applies from the next compare.
  assign expire_o = !clr_i && !disabled &&
                    (count_q == (limit_i - TimeoutWidth'(1)));

  always_comb begin
    count_d = count_q + TimeoutWidth'(1);
    if (clr_i || disabled || expire_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : serial_link_obi_guard_timer
`default_nettype wire

// File: rtl/serial_link_obi_guard.sv
`default_nettype none
// ============================================================================
// Module   : serial_link_obi_guard
// Purpose  : OBI guard in front of the serial-link wrapper. Limits requests in
//            flight and, if the link stops answering for timeout_cycles_i
//            cycles, answers every pending request with an error response.
//            Late responses belonging to timed-out requests are swallowed.
// Ports    : clk_i, rst_ni           - clock, asynchronous active-low reset
//            slv_*                   - upstream OBI slave port
//            mst_*                   - OBI master port toward the link
//            timeout_cycles_i        - timeout in cycles, 0 disables it
//            pending_o               - live outstanding request count
//            timeout_o               - one-cycle pulse per timeout event
//            clr_stats_i             - clears the timeout statistics counter
//            timeout_cnt_o           - saturating timeout counter
// Options  : SERIAL_LINK_OBI_GUARD_STATS_EN - when defined, timeout_cnt_o is
//            a live counter; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module serial_link_obi_guard
  import serial_link_obi_guard_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned TimeoutWidth   = 16,
  parameter logic [31:0] ErrData        = c_err_data_default
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 slv_req_i,
  input  logic [31:0]                          slv_addr_i,
  input  logic                                 slv_we_i,
  input  logic [3:0]                           slv_be_i,
  input  logic [31:0]                          slv_wdata_i,
  output logic                                 slv_gnt_o,
  output logic                                 slv_rvalid_o,
  output logic [31:0]                          slv_rdata_o,
  output logic                                 slv_err_o,
  output logic                                 mst_req_o,
  output logic [31:0]                          mst_addr_o,
  output logic                                 mst_we_o,
  output logic [3:0]                           mst_be_o,
  output logic [31:0]                          mst_wdata_o,
  input  logic                                 mst_gnt_i,
  input  logic                                 mst_rvalid_i,
  input  logic [31:0]                          mst_rdata_i,
  input  logic [TimeoutWidth-1:0]              timeout_cycles_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  pending_o,
  output logic                                 timeout_o,
  input  logic                                 clr_stats_i,
  output logic [c_stats_width-1:0]             timeout_cnt_o
);

  localparam int unsigned           CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0]   MaxCnt   = CntWidth'(MaxOutstanding);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;     // live requests owned by the link
  logic [CntWidth-1:0] drop_q, drop_d;   // stale responses still to swallow
  logic [CntWidth-1:0] flush_q, flush_d; // error responses still to issue

  logic accept_ok;
  logic handshake;
  logic fwd;
  logic swallow;
  logic timer_clr;
  logic expire;

  // Stale responses still occupy link slots, so they count against the limit.
  // cnt+drop never exceeds MaxOutstanding, so the sum fits in CntWidth bits.
  assign accept_ok = (state_q == RUN) && ((cnt_q + drop_q) < MaxCnt);

  assign mst_req_o   = slv_req_i & accept_ok;
  assign mst_addr_o  = slv_addr_i;
  assign mst_we_o    = slv_we_i;
  assign mst_be_o    = slv_be_i;
  assign mst_wdata_o = slv_wdata_i;
  assign slv_gnt_o   = mst_gnt_i & accept_ok;
  assign handshake   = mst_req_o & mst_gnt_i;

  // Link responses are in order: stale ones always come before live ones.
  // A response with drop==0 during FLUSH has no owner and is ignored so it
  // can never collide with an error response upstream.
  assign fwd     = mst_rvalid_i && (drop_q == '0) && (state_q == RUN);
  assign swallow = mst_rvalid_i && (drop_q != '0);

  assign timer_clr = (cnt_q == '0) || fwd || (state_q != RUN);

  serial_link_obi_guard_timer #(
    .TimeoutWidth (TimeoutWidth)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (timer_clr),
    .limit_i  (timeout_cycles_i),
    .expire_o (expire)
  );

  assign timeout_o = expire;
  assign pending_o = cnt_q;

  // Upstream response mux: error responses own the channel in FLUSH.
  always_comb begin
    slv_rvalid_o = 1'b0;
    slv_rdata_o  = '0;
    slv_err_o    = 1'b0;
    if (state_q == FLUSH) begin
      slv_rvalid_o = 1'b1;
      slv_rdata_o  = ErrData;
      slv_err_o    = 1'b1;
    end else if (fwd) begin
      slv_rvalid_o = 1'b1;
      slv_rdata_o  = mst_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    drop_d  = drop_q - CntWidth'(swallow);
    unique case (state_q)
      RUN: begin
        if (expire) begin
          // A request granted on the expiry cycle is already in the link, so
          // it is failed together with the others instead of being lost.
          flush_d = cnt_q + CntWidth'(handshake);
          drop_d  = drop_q - CntWidth'(swallow) + cnt_q + CntWidth'(handshake);
          cnt_d   = '0;
          state_d = FLUSH;
        end else if (handshake && !fwd) begin
          cnt_d = cnt_q + CntWidth'(1);
        end else if (fwd && !handshake) begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      FLUSH: begin
        flush_d = flush_q - CntWidth'(1);
        if (flush_q <= CntWidth'(1)) begin
          flush_d = '0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
      drop_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      flush_q <= flush_d;
    end
  end

`ifdef SERIAL_LINK_OBI_GUARD_STATS_EN
  logic [c_stats_width-1:0] stats_q, stats_d;

  // Clear has priority over a same-cycle timeout; counter saturates.
  always_comb begin
    stats_d = stats_q;
    if (clr_stats_i) begin
      stats_d = '0;
    end else if (expire && (stats_q != '1)) begin
      stats_d = stats_q + c_stats_width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stats_q <= '0;
    end else begin
      stats_q <= stats_d;
    end
  end

  assign timeout_cnt_o = stats_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats_i;
  assign timeout_cnt_o    = '0;
`endif

endmodule : serial_link_obi_guard
`default_nettype wire

// File: tb/tb_serial_link_obi_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_link_obi_guard
// Purpose  : Self-checking bench for serial_link_obi_guard. A count/queue
//            based reference model predicts every output each cycle; directed
//            sequences pin literal values; randomized phases follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_link_obi_guard;

  localparam int          MAXO = 2;
  localparam logic [31:0] KEY  = 32'hCAFE_1001;  // wrapper rdata = addr ^ KEY
  localparam logic [31:0] ERR  = 32'hBADC_AB1E;
`ifdef SERIAL_LINK_OBI_GUARD_STATS_EN
  localparam int          STATS_ON = 1;
`else
  localparam int          STATS_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        slv_req = 0, slv_we = 0, mst_gnt = 0, mst_rvalid = 0, clr_stats = 0;
  logic [31:0] slv_addr = 0, slv_wdata = 0, mst_rdata = 0;
  logic [3:0]  slv_be = 0;
  logic [15:0] tc = 16'd100;

  logic        slv_gnt_o, slv_rvalid_o, slv_err_o, mst_req_o, mst_we_o, timeout_o;
  logic [31:0] slv_rdata_o, mst_addr_o, mst_wdata_o;
  logic [3:0]  mst_be_o;
  logic [1:0]  pending_o;
  logic [15:0] timeout_cnt_o;

  serial_link_obi_guard #(
    .MaxOutstanding (MAXO),
    .TimeoutWidth   (16),
    .ErrData        (ERR)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_req_i        (slv_req),
    .slv_addr_i       (slv_addr),
    .slv_we_i         (slv_we),
    .slv_be_i         (slv_be),
    .slv_wdata_i      (slv_wdata),
    .slv_gnt_o        (slv_gnt_o),
    .slv_rvalid_o     (slv_rvalid_o),
    .slv_rdata_o      (slv_rdata_o),
    .slv_err_o        (slv_err_o),
    .mst_req_o        (mst_req_o),
    .mst_addr_o       (mst_addr_o),
    .mst_we_o         (mst_we_o),
    .mst_be_o         (mst_be_o),
    .mst_wdata_o      (mst_wdata_o),
    .mst_gnt_i        (mst_gnt),
    .mst_rvalid_i     (mst_rvalid),
    .mst_rdata_i      (mst_rdata),
    .timeout_cycles_i (tc),
    .pending_o        (pending_o),
    .timeout_o        (timeout_o),
    .clr_stats_i      (clr_stats),
    .timeout_cnt_o    (timeout_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  int          live, stale, errs, idle, stats;
  logic [31:0] up_q[$];   // upstream addresses awaiting a live response
  logic [31:0] wr_q[$];   // addresses the wrapper still has to answer
  bit          last_up_hs;

  initial begin
    bit          can_acc, fwd_e, swl_e, to_e, hs_e, e_rv, e_err;
    logic [31:0] e_rd;
    int          live0, errs0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        live = 0; stale = 0; errs = 0; idle = 0; stats = 0;
        up_q.delete(); wr_q.delete(); last_up_hs = 0;
      end else begin
        can_acc = (errs == 0) && (live + stale < MAXO);
        fwd_e   = (errs == 0) && mst_rvalid && (stale == 0);
        swl_e   = mst_rvalid && (stale > 0);
        to_e    = (errs == 0) && (live > 0) && (tc != 0) && !fwd_e &&
                  (idle == int'(tc) - 1);
        e_rv = 0; e_err = 0; e_rd = 32'h0;
        if (errs > 0) begin
          e_rv = 1; e_err = 1; e_rd = ERR;
        end else if (fwd_e) begin
          e_rv = 1;
          if (up_q.size() == 0) begin
            total++; bad++;
            $display("FAIL fwd_no_request: actual=rvalid required=no_response t=%0t", $time);
          end else begin
            e_rd = up_q[0] ^ KEY;
          end
        end
        check("mst_req",     32'(mst_req_o),    32'(slv_req & can_acc));
        check("slv_gnt",     32'(slv_gnt_o),    32'(mst_gnt & can_acc));
        check("mst_addr",    mst_addr_o,        slv_addr);
        check("mst_wdata",   mst_wdata_o,       slv_wdata);
        check("mst_we_be",   32'({mst_we_o, mst_be_o}), 32'({slv_we, slv_be}));
        check("slv_rvalid",  32'(slv_rvalid_o), 32'(e_rv));
        check("slv_rdata",   slv_rdata_o,       e_rd);
        check("slv_err",     32'(slv_err_o),    32'(e_err));
        check("timeout",     32'(timeout_o),    32'(to_e));
        check("pending",     32'(pending_o),    32'(live));
        check("timeout_cnt", 32'(timeout_cnt_o), 32'(stats));

        // advance the model by one clock
        hs_e  = slv_req & can_acc & mst_gnt;
        live0 = live;
        errs0 = errs;
        if (swl_e) stale--;
        if (fwd_e) begin
          live--;
          if (up_q.size() > 0) void'(up_q.pop_front());
        end
        if (hs_e) begin
          live++;
          up_q.push_back(slv_addr);
        end
        if (to_e) begin
          errs  = live;
          stale = stale + live;
          live  = 0;
          up_q.delete();
        end else if (errs > 0) begin
          errs--;
        end
        if (to_e || live0 == 0 || fwd_e || tc == 0 || errs0 > 0) idle = 0;
        else idle = (idle + 1) % 65536;
        if (STATS_ON != 0) begin
          if (clr_stats) stats = 0;
          else if (to_e && stats < 65535) stats++;
        end
        // wrapper bookkeeping
        if (mst_rvalid && wr_q.size() > 0) void'(wr_q.pop_front());
        if (mst_req_o & mst_gnt) wr_q.push_back(mst_addr_o);
        last_up_hs = slv_req & slv_gnt_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] resp_data();
    return (wr_q.size() > 0) ? (wr_q[0] ^ KEY) : 32'h0;
  endfunction

  task automatic rand_drive(input int rp, input int gp, input int sp);
    if (!(slv_req && !last_up_hs)) begin
      slv_req   = ($urandom_range(99) < rp);
      slv_addr  = $urandom & 32'hFFFF_FFFC;
      slv_we    = 1'($urandom);
      slv_be    = 4'($urandom);
      slv_wdata = $urandom;
    end
    mst_gnt = ($urandom_range(99) < gp);
    if (wr_q.size() > 0 && $urandom_range(99) < sp) begin
      mst_rvalid = 1; mst_rdata = wr_q[0] ^ KEY;
    end else begin
      mst_rvalid = 0; mst_rdata = $urandom;
    end
    clr_stats = ($urandom_range(199) == 0);
  endtask

  task automatic run_phase(input int tcv, input int rp, input int gp, input int sp,
                           input int n, input bit vary);
    tc = 16'(tcv);
    for (int i = 0; i < n; i++) begin
      tick();
      if (vary && (i % 37 == 0)) tc = 16'($urandom_range(12));
      rand_drive(rp, gp, sp);
    end
  endtask

  initial begin
    int  n;
    bit  found;
    repeat (3) @(posedge clk);
    #2;
    check("rst_gnt",     32'(slv_gnt_o),     32'd0);
    check("rst_rvalid",  32'(slv_rvalid_o),  32'd0);
    check("rst_rdata",   slv_rdata_o,        32'd0);
    check("rst_err",     32'(slv_err_o),     32'd0);
    check("rst_timeout", 32'(timeout_o),     32'd0);
    check("rst_pending", 32'(pending_o),     32'd0);
    check("rst_tcnt",    32'(timeout_cnt_o), 32'd0);
    tick(); rst_n = 1;

    // normal read, response 5 cycles after the handshake
    tick(); slv_req = 1; slv_addr = 32'h1000; slv_be = 4'hF; mst_gnt = 1; #1;
    check("norm_gnt", 32'(slv_gnt_o), 32'd1);
    check("norm_addr", mst_addr_o, 32'h1000);
    tick(); slv_req = 0; mst_gnt = 0; #1;
    check("norm_pend1", 32'(pending_o), 32'd1);
    repeat (3) tick();
    tick(); mst_rvalid = 1; mst_rdata = resp_data(); #1;
    check("norm_rvalid", 32'(slv_rvalid_o), 32'd1);
    check("norm_rdata",  slv_rdata_o, 32'hCAFE0001);
    check("norm_err",    32'(slv_err_o), 32'd0);
    tick(); mst_rvalid = 0; #1;
    check("norm_pend0", 32'(pending_o), 32'd0);

    // outstanding limit
    tick(); slv_req = 1; slv_addr = 32'h2000; mst_gnt = 1; #1;
    check("lim_gnt1", 32'(slv_gnt_o), 32'd1);
    tick(); slv_addr = 32'h2004; #1;
    check("lim_gnt2", 32'(slv_gnt_o), 32'd1);
    tick(); slv_addr = 32'h2008; #1;
    check("lim_gnt3", 32'(slv_gnt_o), 32'd0);
    check("lim_req3", 32'(mst_req_o), 32'd0);
    tick(); mst_rvalid = 1; mst_rdata = resp_data(); tc = 16'd10; #1;
    check("lim_rsp",  32'(slv_rvalid_o), 32'd1);
    check("lim_gnt3b", 32'(slv_gnt_o), 32'd0);
    tick(); mst_rvalid = 0; #1;
    check("lim_gnt3c", 32'(slv_gnt_o), 32'd1);
    tick(); slv_req = 0; mst_gnt = 0;

    // timeout with two outstanding
    n = 2; found = 0;
    while (n < 40 && !found) begin
      tick(); #1; n++;
      if (timeout_o) found = 1;
    end
    check("to_latency", 32'(n), 32'd10);
    tick(); slv_req = 1; slv_addr = 32'h3000; mst_gnt = 1; #1;
    check("fl1_rvalid", 32'(slv_rvalid_o), 32'd1);
    check("fl1_rdata",  slv_rdata_o, 32'hBADCAB1E);
    check("fl1_err",    32'(slv_err_o), 32'd1);
    check("fl1_gnt",    32'(slv_gnt_o), 32'd0);
    check("fl1_req",    32'(mst_req_o), 32'd0);
    tick(); #1;
    check("fl2_rvalid", 32'(slv_rvalid_o), 32'd1);
    check("fl2_err",    32'(slv_err_o), 32'd1);
    check("fl2_gnt",    32'(slv_gnt_o), 32'd0);
    tick(); #1;
    check("fl_end_rvalid", 32'(slv_rvalid_o), 32'd0);
    check("fl_end_gnt",    32'(slv_gnt_o), 32'd0);

    // late responses swallowed
    tick(); mst_rvalid = 1; mst_rdata = resp_data(); #1;
    check("late1_rvalid", 32'(slv_rvalid_o), 32'd0);
    check("late1_gnt",    32'(slv_gnt_o), 32'd0);
    tick(); mst_rdata = resp_data(); #1;
    check("late2_rvalid", 32'(slv_rvalid_o), 32'd0);
    check("late2_gnt",    32'(slv_gnt_o), 32'd1);
    tick(); slv_req = 0; mst_gnt = 0; mst_rvalid = 0; #1;
    check("late_pend", 32'(pending_o), 32'd1);
    tick(); mst_rvalid = 1; mst_rdata = resp_data(); #1;
    check("after_rdata", slv_rdata_o, 32'hCAFE2001);
    tick(); mst_rvalid = 0;

    // response on the expiry cycle wins; timer restarts
    tc = 16'd4;
    tick(); slv_req = 1; slv_addr = 32'h4000; mst_gnt = 1;
    tick(); slv_addr = 32'h4004;
    tick(); slv_req = 0; mst_gnt = 0;
    tick();
    tick(); mst_rvalid = 1; mst_rdata = resp_data(); #1;
    check("race_rvalid",  32'(slv_rvalid_o), 32'd1);
    check("race_rdata",   slv_rdata_o, 32'hCAFE5001);
    check("race_timeout", 32'(timeout_o), 32'd0);
    tick(); mst_rvalid = 0; #1;
    check("race_t1", 32'(timeout_o), 32'd0);
    tick(); #1;
    check("race_t2", 32'(timeout_o), 32'd0);
    tick(); #1;
    check("race_t3", 32'(timeout_o), 32'd0);
    tick(); #1;
    check("race_t4", 32'(timeout_o), 32'd1);
    tick(); #1;
    check("race_fl_err", 32'(slv_err_o), 32'd1);
    tick(); #1;
    check("race_fl_done", 32'(slv_rvalid_o), 32'd0);
    tick(); mst_rvalid = 1; mst_rdata = resp_data(); #1;
    check("race_late", 32'(slv_rvalid_o), 32'd0);
    tick(); mst_rvalid = 0; #1;
    check("race_pend", 32'(pending_o), 32'd0);

    // statistics
    tick(); #1;
    check("stats_two", 32'(timeout_cnt_o), (STATS_ON != 0) ? 32'd2 : 32'd0);
    tick(); clr_stats = 1; #1;
    check("stats_hold", 32'(timeout_cnt_o), (STATS_ON != 0) ? 32'd2 : 32'd0);
    tick(); clr_stats = 0; #1;
    check("stats_clr", 32'(timeout_cnt_o), 32'd0);

    // randomized traffic
    run_phase(20, 60, 70, 40, 2000, 0);
    run_phase(8,  50, 80, 5,  2000, 0);
    run_phase(3,  70, 90, 30, 1500, 0);
    run_phase(0,  60, 60, 15, 1000, 0);
    run_phase(6,  60, 80, 20, 2000, 1);

    tick();
    slv_req = 0; mst_gnt = 0; mst_rvalid = 0; clr_stats = 0;
    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_link_obi_guard
`default_nettype wire
